mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-access stage of the load/store pipe, directly downstream of the address-generation unit. Accepts one issued load or store per handshake, together with its computed effective address, and drives the processor-to-memory command bus with at most one outstanding transaction. Stores use a read-modify-write sequence. Loads are aligned and sign/zero-extended. Completion is held until the CDB/ROB grants it.

## Interface
- `PREG_W`, 6, physical destination tag width
- `ROB_W`, 5, ROB index width
- `clock` in 1: sole clock
- `reset` in 1: asynchronous, active-low
- `issue_valid_in` in 1: issued memory op valid
- `issue_ready_out` out 1: unit idle and able to accept
- `address_in` in 32: effective address from address generation
- `store_data_in` in 32: store source value
- `rd_mem_in`, `wr_mem_in` in 1 each: load / store select (one-hot, or neither)
- `mem_size_in` in 2: 0 byte, 1 half, 2 word
- `mem_unsigned_in` in 1: zero-extend load
- `dest_tag_in` in PREG_W; `rob_idx_in` in ROB_W
- `squash_in` in 1: branch-mispredict flush
- `proc2mem_command` out 2: 0 none, 1 load, 2 store
- `proc2mem_addr` out 32: 8-byte aligned
- `proc2mem_data` out 64
- `mem2proc_response` in 4: nonzero means command accepted, carries the tag
- `mem2proc_data` in 64; `mem2proc_tag` in 4
- `done_valid_out` out 1; `done_is_store_out` out 1; `done_exc_out` out 1
- `done_tag_out` out PREG_W; `done_rob_idx_out` out ROB_W; `done_value_out` out 32
- `done_grant_in` in 1: completion consumed

## Operation
- States:
  - IDLE: `issue_ready_out`=1. A valid issue with `rd_mem_in` or `wr_mem_in` latches all inputs and goes to LD_REQ. A valid issue with neither asserted is ignored.
  - LD_REQ: command=1, addr={addr[31:3],3'b0}. If response≠0, capture the tag and go to LD_WAIT; otherwise stay and retry.
  - LD_WAIT: when `mem2proc_tag` equals the captured tag, capture the 64-bit line.
    - Load: extract the value and go to COMPLETE.
    - Store: merge the store bytes into the line and go to ST_REQ.
  - ST_REQ: command=2 with the merged line. If response≠0, go to COMPLETE; otherwise retry.
  - COMPLETE: `done_valid_out`=1. On `done_grant_in`, go to IDLE.
  - DRAIN: the load was squashed while in flight. Wait for the matching tag, discard the data, then go to IDLE.
- Load extraction:
  - word=line[addr[2]]
  - byte lane=addr[1:0]
  - half lane=addr[1]
  - Sign-extend unless `mem_unsigned_in`.
- Store merge: replace only the addressed byte, half or word; all other bytes of the line are unchanged.
- Store completion: `done_value_out`=0 and `done_is_store_out`=1.
- Stores are issued upstream only at ROB head and are never squashed; `squash_in` affects loads only.
- Squash rules:
  - In LD_REQ: go to IDLE.
  - In LD_WAIT: go to DRAIN.
  - In COMPLETE with a load: go to IDLE, no completion.
  - In IDLE: suppresses an acceptance in the same cycle.
- Tag value 0 never matches.

## Timing
- Reset values: all outputs 0, except `issue_ready_out`=1; state=IDLE.
- Reset asserted mid-transaction abandons it immediately. An outstanding memory response after reset is ignored because the tag register is cleared.
- Accept occurs on the clock edge where `issue_valid_in` and `issue_ready_out` are both high. The command is driven in the next cycle.
- Load latency: 1 (LD_REQ) + memory latency + 1 (COMPLETE) cycles minimum.
- Response and data outputs are registered.
- `mem2proc_tag` matching in the same cycle as acceptance is not possible; the tag is only compared from LD_WAIT onward.
- COMPLETE holds all `done_*` outputs stable until granted. A grant arriving in the same cycle as the first COMPLETE cycle is legal.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A half access with addr[0]≠0, or a word access with addr[1:0]≠0, skips memory entirely and goes IDLE→COMPLETE.
  - `done_exc_out`=1 and `done_value_out`=0.
- Undefined:
  - `done_exc_out` is tied to 0.
  - Misaligned low address bits are ignored: a half uses addr[1], a word uses addr[2] only.

## Structure
- Shared package holds:
  - state enum `MEM_ACC_STATE` {IDLE, LD_REQ, LD_WAIT, ST_REQ, COMPLETE, DRAIN}
  - `MEM_SIZE` enum
  - `BUS_COMMAND` enum {BUS_NONE, BUS_LOAD, BUS_STORE}
- One combinational sub-module, `mem_byte_lane`, performs both load extraction and store merge.

## Test plan
- Word load: addr 0x1004, memory word 0xDEADBEEF, response tag 3, data on tag 3 four cycles later → `done_value_out`=0xDEADBEEF, `done_tag_out` matches the issue tag.
- Signed byte load: addr 0x1003, byte 0x80 → 0xFFFFFF80. Same access with `mem_unsigned_in` → 0x00000080.
- Byte store of 0xAB to addr 0x2002, line 0x1111111111111111 → store command data 0x1111111111AB1111, `done_is_store_out`=1.
- Response 0 for three cycles in LD_REQ → command held for three cycles and accepted on the fourth; `issue_ready_out` stays 0 throughout.
- Squash in LD_WAIT → DRAIN. A later matching tag produces no `done_valid_out`, and `issue_ready_out` returns to 1 the cycle after that tag.
- With `MEM_ALIGN_CHECK_EN`, a word load at 0x1002 → no bus command, `done_exc_out`=1. Completion is held across 2 cycles without grant and released on `done_grant_in`.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-access stage: FSM states, access sizes and bus commands.
package mem_access_unit_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LD_REQ,
      LD_WAIT,
      ST_REQ,
      COMPLETE,
      DRAIN
   } MEM_ACC_STATE;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2,
      MEM_RSVD = 2'd3
   } MEM_SIZE;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } BUS_COMMAND;

   // True when the low address bits are not a multiple of the access size.
   function automatic logic is_misaligned(input MEM_SIZE size, input logic [1:0] lo);
      case (size)
         MEM_BYTE: return 1'b0;
         MEM_HALF: return lo[0];
         default:  return (lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for the 64-bit memory line: load extraction with sign/zero
// extension, and read-modify-write merge of store data.
module mem_byte_lane
   import mem_access_unit_pkg::*;
(
   input  logic [63:0] line,
   input  logic [2:0]  addr_lo,
   input  MEM_SIZE     size,
   input  logic        is_unsigned,
   input  logic [31:0] store_data,
   output logic [31:0] load_value,
   output logic [63:0] merged_line
);

   logic [31:0] word;
   logic [15:0] half;
   logic [7:0]  byte_val;

   always_comb begin
      word        = addr_lo[2] ? line[63:32] : line[31:0];
      half        = addr_lo[1] ? word[31:16] : word[15:0];
      byte_val    = word[{addr_lo[1:0], 3'b000} +: 8];
      load_value  = word;
      merged_line = line;
      case (size)
         MEM_BYTE: begin
            load_value = {{24{byte_val[7] & ~is_unsigned}}, byte_val};
            merged_line[{addr_lo, 3'b000} +: 8] = store_data[7:0];
         end
         MEM_HALF: begin
            load_value = {{16{half[15] & ~is_unsigned}}, half};
            merged_line[{addr_lo[2:1], 4'b0000} +: 16] = store_data[15:0];
         end
         default: begin
            load_value = word;
            merged_line[{addr_lo[2], 5'b00000} +: 32] = store_data;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store memory-access stage: one outstanding bus transaction, RMW stores,
// held completion. Optional MEM_ALIGN_CHECK_EN raises exceptions on misaligned access.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int PREG_W = 6,
   parameter int ROB_W  = 5
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              issue_valid_in,
   output logic              issue_ready_out,
   input  logic [31:0]       address_in,
   input  logic [31:0]       store_data_in,
   input  logic              rd_mem_in,
   input  logic              wr_mem_in,
   input  logic [1:0]        mem_size_in,
   input  logic              mem_unsigned_in,
   input  logic [PREG_W-1:0] dest_tag_in,
   input  logic [ROB_W-1:0]  rob_idx_in,
   input  logic              squash_in,
   output logic [1:0]        proc2mem_command,
   output logic [31:0]       proc2mem_addr,
   output logic [63:0]       proc2mem_data,
   input  logic [3:0]        mem2proc_response,
   input  logic [63:0]       mem2proc_data,
   input  logic [3:0]        mem2proc_tag,
   output logic              done_valid_out,
   output logic              done_is_store_out,
   output logic              done_exc_out,
   output logic [PREG_W-1:0] done_tag_out,
   output logic [ROB_W-1:0]  done_rob_idx_out,
   output logic [31:0]       done_value_out,
   input  logic              done_grant_in
);

   MEM_ACC_STATE      state, next_state;
   BUS_COMMAND        cmd;

   logic [31:0]       addr_q;
   logic [31:0]       sdata_q;
   logic              is_store_q;
   logic              unsigned_q;
   MEM_SIZE           size_q;
   logic [PREG_W-1:0] dtag_q;
   logic [ROB_W-1:0]  rob_q;
   logic [3:0]        mem_tag_q;
   logic [63:0]       line_q;
   logic [31:0]       value_q;
`ifdef MEM_ALIGN_CHECK_EN
   logic              exc_q;
`endif

   logic              accept;
   logic              misalign_in;
   logic              resp_ok;
   logic              tag_hit;
   logic              load_squash;
   logic [31:0]       lane_value;
   logic [63:0]       lane_line;

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign_in = is_misaligned(MEM_SIZE'(mem_size_in), address_in[1:0]);
`else
   assign misalign_in = 1'b0;
`endif

   assign accept      = issue_valid_in && (rd_mem_in || wr_mem_in) && !squash_in;
   assign resp_ok     = (mem2proc_response != 4'd0);
   assign tag_hit     = (mem_tag_q != 4'd0) && (mem2proc_tag == mem_tag_q);
   assign load_squash = squash_in && !is_store_q;

   mem_byte_lane u_lane (
      .line        (mem2proc_data),
      .addr_lo     (addr_q[2:0]),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .store_data  (sdata_q),
      .load_value  (lane_value),
      .merged_line (lane_line)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:
            if (accept) next_state = misalign_in ? COMPLETE : LD_REQ;
         LD_REQ:
            // A squash racing an accepted request must still drain its response.
            if (load_squash)  next_state = resp_ok ? DRAIN : IDLE;
            else if (resp_ok) next_state = LD_WAIT;
         LD_WAIT:
            if (load_squash)  next_state = tag_hit ? IDLE : DRAIN;
            else if (tag_hit) next_state = is_store_q ? ST_REQ : COMPLETE;
         ST_REQ:
            if (resp_ok) next_state = COMPLETE;
         COMPLETE:
            if (done_grant_in || load_squash) next_state = IDLE;
         DRAIN:
            if (tag_hit) next_state = IDLE;
         default:
            next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_q     <= '0;
         sdata_q    <= '0;
         is_store_q <= 1'b0;
         unsigned_q <= 1'b0;
         size_q     <= MEM_BYTE;
         dtag_q     <= '0;
         rob_q      <= '0;
         mem_tag_q  <= '0;
         line_q     <= '0;
         value_q    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
         exc_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE:
               if (accept) begin
                  addr_q     <= address_in;
                  sdata_q    <= store_data_in;
                  is_store_q <= wr_mem_in;
                  unsigned_q <= mem_unsigned_in;
                  size_q     <= MEM_SIZE'(mem_size_in);
                  dtag_q     <= dest_tag_in;
                  rob_q      <= rob_idx_in;
                  mem_tag_q  <= '0;
                  value_q    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
                  exc_q      <= misalign_in;
`endif
               end
            LD_REQ:
               if (resp_ok) mem_tag_q <= mem2proc_response;
            LD_WAIT:
               if (tag_hit) begin
                  line_q  <= lane_line;
                  value_q <= is_store_q ? '0 : lane_value;
               end
            default: ;
         endcase
      end
   end

   always_comb begin
      cmd             = BUS_NONE;
      proc2mem_addr   = '0;
      proc2mem_data   = '0;
      issue_ready_out = (state == IDLE);
      done_valid_out  = (state == COMPLETE);
      case (state)
         LD_REQ: begin
            cmd           = BUS_LOAD;
            proc2mem_addr = {addr_q[31:3], 3'b000};
         end
         ST_REQ: begin
            cmd           = BUS_STORE;
            proc2mem_addr = {addr_q[31:3], 3'b000};
            proc2mem_data = line_q;
         end
         default: ;
      endcase
      proc2mem_command = cmd;
   end

   assign done_is_store_out = is_store_q;
   assign done_tag_out      = dtag_q;
   assign done_rob_idx_out  = rob_q;
   assign done_value_out    = value_q;
`ifdef MEM_ALIGN_CHECK_EN
   assign done_exc_out      = exc_q;
`else
   assign done_exc_out      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written squash/reset/stall
// sequences, and randomized ops against a byte-level memory reference model.
module tb_mem_access_unit;

   logic        clock, reset;
   logic        issue_valid_in, issue_ready_out;
   logic [31:0] address_in, store_data_in;
   logic        rd_mem_in, wr_mem_in;
   logic [1:0]  mem_size_in;
   logic        mem_unsigned_in;
   logic [5:0]  dest_tag_in;
   logic [4:0]  rob_idx_in;
   logic        squash_in;
   logic [1:0]  proc2mem_command;
   logic [31:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   logic [3:0]  mem2proc_response;
   logic [63:0] mem2proc_data;
   logic [3:0]  mem2proc_tag;
   logic        done_valid_out, done_is_store_out, done_exc_out;
   logic [5:0]  done_tag_out;
   logic [4:0]  done_rob_idx_out;
   logic [31:0] done_value_out;
   logic        done_grant_in;

   mem_access_unit #(.PREG_W(6), .ROB_W(5)) dut (
      .clock(clock), .reset(reset),
      .issue_valid_in(issue_valid_in), .issue_ready_out(issue_ready_out),
      .address_in(address_in), .store_data_in(store_data_in),
      .rd_mem_in(rd_mem_in), .wr_mem_in(wr_mem_in),
      .mem_size_in(mem_size_in), .mem_unsigned_in(mem_unsigned_in),
      .dest_tag_in(dest_tag_in), .rob_idx_in(rob_idx_in), .squash_in(squash_in),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
      .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
      .done_valid_out(done_valid_out), .done_is_store_out(done_is_store_out),
      .done_exc_out(done_exc_out), .done_tag_out(done_tag_out),
      .done_rob_idx_out(done_rob_idx_out), .done_value_out(done_value_out),
      .done_grant_in(done_grant_in)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int tick_no = 0;

   logic [63:0] bus_mem [logic [31:0]];
   logic [63:0] ref_mem [logic [31:0]];

   typedef struct { int tag; int due; logic [63:0] data; } pend_t;
   pend_t pend[$];

   int          mem_lat = 1, stall_cfg = 0, stall_left = 0, next_tag = 1, newcmds = 0;
   logic [1:0]  prev_cmd = 2'd0;
   logic [31:0] cur_line = '0;
   int          sq_n = -1;

   logic [31:0] o_value;
   logic        o_store, o_exc, o_done, o_busy, o_unstable, o_idle_after;
   logic [5:0]  o_tag, exp_dtag;
   logic [4:0]  o_rob, exp_rob;
   int          o_lat, o_ldcmd;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] init_line(input logic [31:0] la);
      return {la ^ 32'h5A5A0F0F, ~la ^ 32'h9E3779B1};
   endfunction

   function automatic logic [63:0] bus_get(input logic [31:0] la);
      return bus_mem.exists(la) ? bus_mem[la] : init_line(la);
   endfunction

   function automatic logic [63:0] ref_get(input logic [31:0] la);
      return ref_mem.exists(la) ? ref_mem[la] : init_line(la);
   endfunction

   function automatic int nbytes(input int sz);
      return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [63:0] line, input logic [31:0] a,
                                            input int sz, input bit uns);
      int nb, base;
      logic [63:0] sh;
      logic [31:0] v, m;
      nb   = nbytes(sz);
      base = int'(a[2:0]) / nb * nb;
      sh   = line >> (base * 8);
      v    = sh[31:0];
      if (nb < 4) begin
         m = (32'd1 << (nb * 8)) - 32'd1;
         v = v & m;
         if (!uns && v[nb*8-1]) v = v | ~m;
      end
      return v;
   endfunction

   function automatic logic [63:0] ref_store(input logic [63:0] line, input logic [31:0] a,
                                             input int sz, input logic [31:0] sd);
      int nb, base;
      logic [31:0] m;
      logic [63:0] m64, d64;
      nb   = nbytes(sz);
      base = int'(a[2:0]) / nb * nb;
      m    = (nb == 4) ? 32'hFFFFFFFF : (32'd1 << (nb * 8)) - 32'd1;
      m64  = {32'h0, m} << (base * 8);
      d64  = {32'h0, sd & m} << (base * 8);
      return (line & ~m64) | d64;
   endfunction

   function automatic bit misaligned(input int sz, input logic [31:0] a);
      return (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
   endfunction

   // Memory side of the bus, evaluated once per cycle at the falling edge.
   task automatic mem_tick();
      mem2proc_response = 4'd0;
      mem2proc_tag      = 4'd0;
      mem2proc_data     = 64'd0;
      if (pend.size() > 0 && pend[0].due == tick_no) begin
         mem2proc_tag  = 4'(pend[0].tag);
         mem2proc_data = pend[0].data;
         void'(pend.pop_front());
      end
      if (proc2mem_command != 2'd0) begin
         if (proc2mem_command != prev_cmd) begin
            stall_left = stall_cfg;
            newcmds++;
            chk("bus_addr", proc2mem_addr, cur_line);
         end
         if (stall_left > 0) stall_left--;
         else begin
            mem2proc_response = 4'(next_tag);
            if (proc2mem_command == 2'd1)
               pend.push_back('{next_tag, tick_no + mem_lat, bus_get(proc2mem_addr)});
            else
               bus_mem[proc2mem_addr] = proc2mem_data;
            next_tag = (next_tag == 15) ? 1 : next_tag + 1;
         end
      end
      prev_cmd = proc2mem_command;
   endtask

   task automatic tick();
      @(negedge clock);
      tick_no++;
      mem_tick();
   endtask

   // Issue one op (DUT must be idle, called right after a tick) and collect its completion.
   task automatic run_op(input logic [31:0] a, input logic [31:0] sd, input bit rd, input bit wr,
                         input int sz, input bit uns, input int lat, input int stall,
                         input int gdelay);
      int n;
      cur_line   = {a[31:3], 3'b000};
      mem_lat    = lat;
      stall_cfg  = stall;
      newcmds    = 0;
      exp_dtag   = 6'($urandom);
      exp_rob    = 5'($urandom);
      o_busy     = 1'b0;
      o_unstable = 1'b0;
      o_ldcmd    = 0;
      issue_valid_in  = 1'b1;
      address_in      = a;
      store_data_in   = sd;
      rd_mem_in       = rd;
      wr_mem_in       = wr;
      mem_size_in     = 2'(sz);
      mem_unsigned_in = uns;
      dest_tag_in     = exp_dtag;
      rob_idx_in      = exp_rob;
      tick();
      issue_valid_in = 1'b0;
      rd_mem_in      = 1'b0;
      wr_mem_in      = 1'b0;
      address_in     = $urandom;
      store_data_in  = $urandom;
      n = 1;
      while (!done_valid_out && n < 300) begin
         if (issue_ready_out) o_busy = 1'b1;
         if (proc2mem_command == 2'd1) o_ldcmd++;
         squash_in = (n == sq_n);
         tick();
         n++;
      end
      squash_in = 1'b0;
      o_lat  = n;
      o_done = done_valid_out;
      chk("done_seen", done_valid_out, 1'b1);
      if (!o_done) return;
      o_value = done_value_out;
      o_store = done_is_store_out;
      o_exc   = done_exc_out;
      o_tag   = done_tag_out;
      o_rob   = done_rob_idx_out;
      for (int g = 0; g < gdelay; g++) begin
         tick();
         if (!done_valid_out || done_value_out !== o_value || done_is_store_out !== o_store ||
             done_exc_out !== o_exc || done_tag_out !== o_tag || done_rob_idx_out !== o_rob)
            o_unstable = 1'b1;
      end
      done_grant_in = 1'b1;
      tick();
      done_grant_in = 1'b0;
      o_idle_after = issue_ready_out && !done_valid_out;
   endtask

   // Run an op with all expectations taken from the reference model.
   task automatic model_op(input logic [31:0] a, input logic [31:0] sd, input bit wr,
                           input int sz, input bit uns, input int lat, input int stall,
                           input int gdelay);
      logic [31:0] la, ev;
      logic [63:0] el;
      bit          exc;
      int          elat;
      la  = {a[31:3], 3'b000};
      el  = ref_get(la);
      ev  = '0;
      exc = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      exc = misaligned(sz, a);
`endif
      if (exc) elat = 1;
      else if (wr) begin
         el   = ref_store(el, a, sz, sd);
         elat = 3 + lat + 2 * stall;
      end else begin
         ev   = ref_load(el, a, sz, uns);
         elat = 2 + lat + stall;
      end
      ref_mem[la] = el;
      run_op(a, sd, !wr, wr, sz, uns, lat, stall, gdelay);
      if (!o_done) return;
      chk("value", o_value, ev);
      chk("is_store", o_store, wr);
      chk("exc", o_exc, exc);
      chk("dest_tag", o_tag, exp_dtag);
      chk("rob_idx", o_rob, exp_rob);
      chk("latency", o_lat, elat);
      chk("done_stable", o_unstable, 1'b0);
      chk("idle_after_grant", o_idle_after, 1'b1);
      chk("mem_line", bus_get(la), el);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] sdata;
      bit          wr;
      int          sz;
      bit          uns;
      logic [63:0] line;
      logic [31:0] exp_val;
      logic [63:0] exp_line;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int          n, guard;
      bit          seen_done, early_ready;
      logic [31:0] la;

      vecs[0] = '{32'h1004, 32'h0,        1'b0, 2, 1'b0, 64'hDEADBEEF_00000000, 32'hDEADBEEF, 64'hDEADBEEF_00000000};
      vecs[1] = '{32'h1003, 32'h0,        1'b0, 0, 1'b0, 64'h00000000_80000000, 32'hFFFFFF80, 64'h00000000_80000000};
      vecs[2] = '{32'h1003, 32'h0,        1'b0, 0, 1'b1, 64'h00000000_80000000, 32'h00000080, 64'h00000000_80000000};
      vecs[3] = '{32'h2002, 32'h000000AB, 1'b1, 0, 1'b0, 64'h11111111_11111111, 32'h0,        64'h11111111_11AB1111};
      vecs[4] = '{32'h1006, 32'h0,        1'b0, 1, 1'b0, 64'h80010000_00000000, 32'hFFFF8001, 64'h80010000_00000000};
      vecs[5] = '{32'h1002, 32'h0,        1'b0, 1, 1'b1, 64'h00000000_F00D0000, 32'h0000F00D, 64'h00000000_F00D0000};
      vecs[6] = '{32'h3004, 32'h12345678, 1'b1, 1, 1'b0, 64'h00000000_00000000, 32'h0,        64'h00005678_00000000};
      vecs[7] = '{32'h3800, 32'h01234567, 1'b1, 2, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 32'h0,        64'hFFFFFFFF_01234567};
      vecs[8] = '{32'h1005, 32'h0,        1'b0, 0, 1'b0, 64'h00007F00_00000000, 32'h0000007F, 64'h00007F00_00000000};

      reset = 1'b0;
      issue_valid_in = 1'b0; address_in = '0; store_data_in = '0;
      rd_mem_in = 1'b0; wr_mem_in = 1'b0; mem_size_in = '0; mem_unsigned_in = 1'b0;
      dest_tag_in = '0; rob_idx_in = '0; squash_in = 1'b0; done_grant_in = 1'b0;
      mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
      repeat (3) tick();
      chk("rst_ready", issue_ready_out, 1'b1);
      chk("rst_cmd", proc2mem_command, 2'd0);
      chk("rst_addr", proc2mem_addr, 32'd0);
      chk("rst_data", proc2mem_data, 64'd0);
      chk("rst_done_valid", done_valid_out, 1'b0);
      chk("rst_done_fields", {done_is_store_out, done_exc_out, done_tag_out, done_rob_idx_out, done_value_out}, 64'd0);
      reset = 1'b1;
      tick();

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         la = {vecs[i].addr[31:3], 3'b000};
         bus_mem[la] = vecs[i].line;
         ref_mem[la] = vecs[i].line;
         if (i == 0) next_tag = 3;
         run_op(vecs[i].addr, vecs[i].sdata, !vecs[i].wr, vecs[i].wr, vecs[i].sz, vecs[i].uns, 4, 0, 0);
         if (o_done) begin
            chk($sformatf("vec%0d_value", i), o_value, vecs[i].exp_val);
            chk($sformatf("vec%0d_is_store", i), o_store, vecs[i].wr);
            chk($sformatf("vec%0d_tag", i), o_tag, exp_dtag);
            chk($sformatf("vec%0d_line", i), bus_get(la), vecs[i].exp_line);
            chk($sformatf("vec%0d_latency", i), o_lat, vecs[i].wr ? 7 : 6);
         end
         if (vecs[i].wr) ref_mem[la] = vecs[i].exp_line;
      end

      // Response refused for three cycles in LD_REQ
      model_op(32'h1010, 32'h0, 1'b0, 2, 1'b0, 2, 3, 0);
      chk("stall_cmd_cycles", o_ldcmd, 4);
      chk("stall_ready_low", o_busy, 1'b0);

      // Completion held for two cycles before grant
      model_op(32'h1018, 32'h0, 1'b0, 1, 1'b0, 1, 0, 2);

      // Squash in LD_WAIT: drain the response, never complete
      cur_line = 32'h1100; mem_lat = 6; stall_cfg = 0;
      issue_valid_in = 1'b1; rd_mem_in = 1'b1; address_in = 32'h1104; mem_size_in = 2'd2;
      tick();
      issue_valid_in = 1'b0; rd_mem_in = 1'b0;
      tick();
      squash_in = 1'b1;
      tick();
      squash_in = 1'b0;
      seen_done = 1'b0; early_ready = 1'b0; guard = 0;
      while (pend.size() > 0 && guard < 50) begin
         if (done_valid_out) seen_done = 1'b1;
         if (issue_ready_out) early_ready = 1'b1;
         tick();
         guard++;
      end
      chk("drain_tag_delivered", pend.size(), 0);
      chk("drain_ready_at_tag", issue_ready_out, 1'b0);
      tick();
      chk("drain_ready_after", issue_ready_out, 1'b1);
      chk("drain_no_done", seen_done | done_valid_out, 1'b0);
      chk("drain_busy", early_ready, 1'b0);

      // Squash in LD_REQ
      cur_line = 32'h1200; stall_cfg = 5;
      issue_valid_in = 1'b1; rd_mem_in = 1'b1; address_in = 32'h1200; mem_size_in = 2'd2;
      tick();
      issue_valid_in = 1'b0; rd_mem_in = 1'b0;
      squash_in = 1'b1;
      tick();
      squash_in = 1'b0; stall_cfg = 0;
      chk("sqreq_ready", issue_ready_out, 1'b1);
      chk("sqreq_cmd", proc2mem_command, 2'd0);

      // Squash of a load waiting in COMPLETE
      cur_line = 32'h1300; mem_lat = 1;
      issue_valid_in = 1'b1; rd_mem_in = 1'b1; address_in = 32'h1300; mem_size_in = 2'd2;
      tick();
      issue_valid_in = 1'b0; rd_mem_in = 1'b0;
      n = 0;
      while (!done_valid_out && n < 50) begin tick(); n++; end
      chk("sqc_done_seen", done_valid_out, 1'b1);
      squash_in = 1'b1;
      tick();
      squash_in = 1'b0;
      chk("sqc_no_done", done_valid_out, 1'b0);
      chk("sqc_ready", issue_ready_out, 1'b1);

      // Squash in IDLE suppresses acceptance
      issue_valid_in = 1'b1; rd_mem_in = 1'b1; squash_in = 1'b1; address_in = 32'h1400;
      tick();
      issue_valid_in = 1'b0; rd_mem_in = 1'b0; squash_in = 1'b0;
      chk("sqidle_ready", issue_ready_out, 1'b1);
      chk("sqidle_cmd", proc2mem_command, 2'd0);

      // Valid issue with neither load nor store is ignored
      issue_valid_in = 1'b1; address_in = 32'h1500;
      tick();
      issue_valid_in = 1'b0;
      chk("noop_ready", issue_ready_out, 1'b1);
      chk("noop_cmd", proc2mem_command, 2'd0);

      // A store ignores squash while in flight
      sq_n = 2;
      model_op(32'h2104, 32'hCAFEF00D, 1'b1, 2, 1'b0, 3, 0, 0);
      sq_n = -1;

      // Reset mid-transaction abandons it; the stale response is ignored
      cur_line = 32'h1600; mem_lat = 6;
      issue_valid_in = 1'b1; rd_mem_in = 1'b1; address_in = 32'h1600; mem_size_in = 2'd2;
      tick();
      issue_valid_in = 1'b0; rd_mem_in = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      chk("midrst_ready", issue_ready_out, 1'b1);
      chk("midrst_cmd", proc2mem_command, 2'd0);
      tick();
      reset = 1'b1;
      seen_done = 1'b0; guard = 0;
      while (pend.size() > 0 && guard < 50) begin
         tick();
         if (done_valid_out) seen_done = 1'b1;
         guard++;
      end
      tick();
      chk("midrst_no_done", seen_done | done_valid_out, 1'b0);
      chk("midrst_ready_after", issue_ready_out, 1'b1);

      // Misaligned word load: exception with the check enabled, plain access otherwise
      model_op(32'h1002, 32'h0, 1'b0, 2, 1'b0, 2, 0, 2);
`ifdef MEM_ALIGN_CHECK_EN
      chk("misalign_no_bus", newcmds, 0);
`endif

      // Randomized ops against the reference model
      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         a = 32'h4000 + ($urandom_range(0, 7) << 3) + $urandom_range(0, 7);
         model_op(a, $urandom, ($urandom_range(0, 2) == 0), $urandom_range(0, 2),
                  1'($urandom_range(0, 1)), $urandom_range(1, 5), $urandom_range(0, 2),
                  $urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
